// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - user-side inputs and board-side pins of the 7-segment scan driver
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_suppress;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    CA, CB, CC, CD, CE, CF, CG;
  logic                    DP;
  logic                    frame_start;

  modport master (
    output value, dp_in, digit_en, lz_suppress,
    input  AN, CA, CB, CC, CD, CE, CF, CG, DP, frame_start
  );

  modport slave (
    input  value, dp_in, digit_en, lz_suppress,
    output AN, CA, CB, CC, CD, CE, CF, CG, DP, frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit 7-segment driver with blanking,
// leading-zero suppression and a per-frame input snapshot; all pins registered
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int DIV_CYCLES     = 100000,
  parameter int BLANK_CYCLES   = 1000,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic              CLK100MHZ,
  input logic              CPU_RESETN,
  seg7_scan_driver_if.slave bus
);
  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;

  logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
  logic                    load_pending_q, load_pending_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    lz_q, lz_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_pin_q, dp_pin_d;
  logic                    frame_q, frame_d;

  logic                    div_wrap, idx_wrap, snap_load, lit, zero_above;
  logic [NUM_DIGITS-1:0]   supp;
  logic [3:0]              nib;
  logic [6:0]              seg_hi;
  logic [NUM_DIGITS-1:0]   an_hi;

  always_comb begin
    div_wrap    = (div_cnt_q == CNT_W'(DIV_CYCLES - 1));
    idx_wrap    = (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
    div_cnt_d   = div_wrap ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (div_wrap) begin
      digit_idx_d = idx_wrap ? '0 : digit_idx_q + 1'b1;
    end

    // Snapshot lands on the same edge digit_idx returns to 0, so a whole frame sees one value
    snap_load      = load_pending_q || (div_wrap && idx_wrap);
    load_pending_d = 1'b0;
    value_d        = snap_load ? bus.value       : value_q;
    dp_d           = snap_load ? bus.dp_in       : dp_q;
    en_d           = snap_load ? bus.digit_en    : en_q;
    lz_d           = snap_load ? bus.lz_suppress : lz_q;

    supp       = '0;
    zero_above = lz_q;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (value_q[4*i +: 4] == 4'h0);
      supp[i]    = zero_above;
    end

    nib    = 4'(value_q >> (4 * digit_idx_q));
    seg_hi = 7'h00;
    case (nib)
      4'h0: seg_hi = 7'h3F;
      4'h1: seg_hi = 7'h06;
      4'h2: seg_hi = 7'h5B;
      4'h3: seg_hi = 7'h4F;
      4'h4: seg_hi = 7'h66;
      4'h5: seg_hi = 7'h6D;
      4'h6: seg_hi = 7'h7D;
      4'h7: seg_hi = 7'h07;
      4'h8: seg_hi = 7'h7F;
      4'h9: seg_hi = 7'h6F;
      4'hA: seg_hi = 7'h77;
      4'hB: seg_hi = 7'h7C;
      4'hC: seg_hi = 7'h39;
      4'hD: seg_hi = 7'h5E;
      4'hE: seg_hi = 7'h79;
      4'hF: seg_hi = 7'h71;
      default: seg_hi = 7'h00;
    endcase

    // Only the anodes are gated by blanking; segments carry the digit for the whole slot
    lit   = (div_cnt_q >= CNT_W'(BLANK_CYCLES)) && en_q[digit_idx_q] && !supp[digit_idx_q];
    an_hi = '0;
    if (lit) begin
      an_hi[digit_idx_q] = 1'b1;
    end

    an_d     = AN_ACTIVE_LOW ? ~an_hi : an_hi;
    seg_d    = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    dp_pin_d = SEG_ACTIVE_LOW ? ~dp_q[digit_idx_q] : dp_q[digit_idx_q];
    frame_d  = (div_cnt_q == '0) && (digit_idx_q == '0);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      div_cnt_q      <= '0;
      digit_idx_q    <= '0;
      load_pending_q <= 1'b1;
      value_q        <= '0;
      dp_q           <= '0;
      en_q           <= '0;
      lz_q           <= 1'b0;
      an_q           <= AN_OFF;
      seg_q          <= SEG_OFF;
      dp_pin_q       <= DP_OFF;
      frame_q        <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      digit_idx_q    <= digit_idx_d;
      load_pending_q <= load_pending_d;
      value_q        <= value_d;
      dp_q           <= dp_d;
      en_q           <= en_d;
      lz_q           <= lz_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_pin_q       <= dp_pin_d;
      frame_q        <= frame_d;
    end
  end

  assign bus.AN = an_q;
  assign {bus.CG, bus.CF, bus.CE, bus.CD, bus.CC, bus.CB, bus.CA} = seg_q;
  assign bus.DP          = dp_pin_q;
  assign bus.frame_start = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized bench for seg7_scan_driver against a cycle-count model
module tb_seg7_scan_driver;
  localparam int ND    = 8;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = ND * DIV;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: edges since reset release plus the frame snapshot it believes is in force
  int          m_t;
  bit          m_first;
  logic [31:0] s_val;
  logic [7:0]  s_dp, s_en;
  logic        s_lz;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .DIV_CYCLES(DIV), .BLANK_CYCLES(BLANK),
    .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) assert ($countones(~bus.AN) <= 1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, m_t, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_pins();
    return {bus.CG, bus.CF, bus.CE, bus.CD, bus.CC, bus.CB, bus.CA};
  endfunction

  task automatic model_reset();
    m_t = 0; m_first = 1'b1;
    s_val = '0; s_dp = '0; s_en = '0; s_lz = 1'b0;
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_an"},  32'(bus.AN), 32'hFF);
    check({tag, "_seg"}, 32'(seg_pins()), 32'h7F);
    check({tag, "_dp"},  32'(bus.DP), 32'h1);
    check({tag, "_fs"},  32'(bus.frame_start), 32'h0);
  endtask

  task automatic step();
    int div, idx;
    bit supp, lit;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fs;
    @(posedge clk);
    div  = m_t % DIV;
    idx  = (m_t / DIV) % ND;
    supp = s_lz && (idx > 0) && ((s_val >> (4 * idx)) == 0);
    lit  = (div >= BLANK) && s_en[idx] && !supp;
    e_an  = lit ? ~(8'h01 << idx) : 8'hFF;
    e_seg = ~SEG_TAB[(s_val >> (4 * idx)) & 32'hF];
    e_dp  = ~s_dp[idx];
    e_fs  = (div == 0) && (idx == 0);
    if (m_first || ((m_t + 1) % FRAME == 0)) begin
      s_val = bus.value; s_dp = bus.dp_in; s_en = bus.digit_en; s_lz = bus.lz_suppress;
    end
    m_first = 1'b0;
    m_t++;
    #1;
    check("an",     32'(bus.AN), 32'(e_an));
    check("seg",    32'(seg_pins()), 32'(e_seg));
    check("dp",     32'(bus.DP), 32'(e_dp));
    check("frame",  32'(bus.frame_start), 32'(e_fs));
    check("onehot", 32'($countones(~bus.AN) <= 1), 32'h1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int k;
    bit found;
    bus.value = 32'h76543210; bus.dp_in = 8'h00; bus.digit_en = 8'hFF; bus.lz_suppress = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_pins("reset");

    @(negedge clk) rst_n = 1'b1;
    model_reset();
    run(2 * FRAME + 10);

    bus.value = 32'h00000A05; bus.lz_suppress = 1'b1;
    run(2 * FRAME);
    bus.value = 32'h0;
    run(2 * FRAME);

    found = 1'b0;
    for (int i = 0; i < FRAME && !found; i++) begin
      if ((m_t / DIV) % ND == 3) found = 1'b1;
      else step();
    end
    check("reach_digit3", 32'(found), 32'h1);
    bus.value = 32'h89ABCDEF; bus.lz_suppress = 1'b0;
    run(2 * FRAME);

    bus.digit_en = 8'h0F; bus.dp_in = 8'h02; bus.value = $urandom;
    run(2 * FRAME);

    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(0, 8);
      bus.value       = (k == 8) ? 32'h0 : ($urandom >> (4 * k));
      bus.dp_in       = 8'($urandom);
      bus.digit_en    = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      bus.lz_suppress = 1'($urandom);
      run($urandom_range(1, 100));
    end

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_pins("async_reset");
    model_reset();
    @(posedge clk);
    #1 check_reset_pins("reset_hold");
    bus.value = 32'h0000_1234; bus.digit_en = 8'hFF; bus.dp_in = 8'h80; bus.lz_suppress = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    run(FRAME + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
